// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the console UART transmitter: byte push strobe, sticky
// overflow clear, and the FIFO status returned to the polling writer.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          ovf_clr;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  modport master (
    output wr_en, wr_data, ovf_clr,
    input  fifo_full, fifo_empty, fifo_count, overflow
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr,
    output fifo_full, fifo_empty, fifo_count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Console UART transmitter: synchronous byte FIFO feeding an 8N1 serializer
// that runs frames back to back while data is buffered.
module uart_tx_fifo #(
  parameter int DEPTH        = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave host,
  output logic          busy,
  output logic          tx
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_TC = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [BW-1:0] baud_cnt, baud_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt;
  logic          push, pop, full, empty, baud_tc;
  logic          overflow;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = host.wr_en && !full;

  assign host.fifo_full  = full;
  assign host.fifo_empty = empty;
  assign host.fifo_count = wr_ptr - rd_ptr;
  assign host.overflow   = overflow;

  assign baud_tc = (baud_cnt == BAUD_TC);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= host.wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // A dropped write in the same cycle as a clear leaves the flag set.
      if (host.wr_en && full) overflow <= 1'b1;
      else if (host.ovf_clr)  overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      tx       <= tx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_nxt;
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    tx_nxt    = tx;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr[AW-1:0]];
          tx_nxt    = 1'b0;
          baud_nxt  = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (baud_tc) begin
          baud_nxt  = '0;
          tx_nxt    = shift[0];
          bit_nxt   = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_tc) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            shift_nxt = shift >> 1;
            tx_nxt    = shift[1];
            bit_nxt   = bit_idx + 1'b1;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_tc) begin
          baud_nxt = '0;
          // Chain straight into the next start bit so frames have no gap.
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr[AW-1:0]];
            tx_nxt    = 1'b0;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
